conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Top-level controller for the Gaussian convolution path.
- Issues the transaction start to the sliding-window buffer (conv_memory) and to the raster position tracker (pixel_pos).
- For every output pixel: waits for a ready window, latches it, steps the position, starts the convolution engine, waits for its result, and writes the result to the output image SRAM.
- Sits between the host/frame controller and the conv_memory / pixel_pos / gaussian-conv trio.

Parameters:
- X_MAX, 60, image width bound; sets position and address widths.
- Y_MAX, 60, image height bound.
- PIXEL_DEPTH, 8, pixel/result width.
- TIMEOUT_CYCLES, 1023, max cycles allowed in any wait state before error.
- CNT_W, 12, width of the processed-pixel counter.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a frame (accepted only in IDLE or ERROR).
- abort  in  1  level: return to IDLE immediately.
- new_trans  out  1  one-cycle pulse to conv_memory and pixel_pos: reset the window and position.
- new_sample_ready  in  1  from conv_memory: window complete.
- new_sample_req  out  1  one-cycle pulse to conv_memory: latch the window and shift.
- update_pos  out  1  one-cycle pulse to pixel_pos: advance position.
- end_pos  in  1  from pixel_pos: current position is the last of the frame.
- curr_x  in  $clog2(X_MAX)  current window x from pixel_pos.
- curr_y  in  $clog2(Y_MAX)  current window y.
- conv_start  out  1  one-cycle pulse to the convolution engine.
- conv_done  in  1  engine result valid (single-cycle pulse).
- conv_result  in  PIXEL_DEPTH  engine output pixel.
- wen_out  out  1  output SRAM write enable.
- x_addr_out  out  $clog2(X_MAX)  write x address.
- y_addr_out  out  $clog2(Y_MAX)  write y address.
- wdat_out  out  PIXEL_DEPTH  write data.
- busy  out  1  high in any state except IDLE, DONE and ERROR.
- done  out  1  one-cycle pulse when the frame is complete.
- err  out  1  sticky timeout flag.
- pix_count  out  CNT_W  pixels written in the current frame.

Behaviour:
- Reset: state=IDLE; every output 0; internal address/data/last registers 0; timeout counter 0.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.

State machine:
- IDLE: on start -> INIT; clear pix_count and err.
- INIT: assert new_trans for exactly 1 cycle -> WAIT_SAMPLE.
- WAIT_SAMPLE: wait for new_sample_ready=1 -> LATCH.
- LATCH (1 cycle):
  - assert new_sample_req.
  - capture curr_x/curr_y into x_addr_out/y_addr_out; capture last=end_pos.
  - assert update_pos only if end_pos=0.
  - -> CONV.
- CONV (1 cycle): assert conv_start -> CONV_WAIT. The engine reads working_memory one cycle after the latch, so it sees the new window.
- CONV_WAIT: on conv_done, capture conv_result into wdat_out -> WRITE.
- WRITE (1 cycle):
  - assert wen_out with the captured address and data.
  - pix_count+1, saturating at all-ones.
  - -> DONE if last=1, else -> WAIT_SAMPLE.
- DONE: done=1 for 1 cycle -> IDLE.
- ERROR: err=1 stays high. start clears err and -> INIT. abort -> IDLE with err held at 1.

Timeout:
- One counter runs in WAIT_SAMPLE and CONV_WAIT; it clears on every state entry.
- When the count reaches TIMEOUT_CYCLES and the awaited input is still low -> ERROR.
- If the awaited input arrives in the same cycle the timeout would fire, the input wins.

Boundary rules:
- abort beats every other event:
  - from any non-IDLE state, next state=IDLE.
  - all pulses (new_trans, new_sample_req, update_pos, conv_start, wen_out, done) are 0 in the abort cycle and after it.
  - a partially processed pixel is not written.
- start outside IDLE/ERROR is ignored.
- start and abort together in IDLE: stay in IDLE.
- A conv_done that arrives outside CONV_WAIT is ignored.
- A new_sample_ready that arrives outside WAIT_SAMPLE is ignored (conv_memory holds ready until req).
- Single-pixel frame (end_pos=1 at the first LATCH): exactly one write, no update_pos, then done.
- Asynchronous reset mid-frame: immediate return to the reset values; no write is issued.

Latency:
- start -> new_trans: 1 cycle.
- new_sample_ready -> new_sample_req: 1 cycle.
- conv_done -> wen_out: 1 cycle.
- Minimum per-pixel overhead beyond the two waits: LATCH + CONV + WRITE = 3 cycles.

Test Plan:
- Reset, then a start pulse -> new_trans high exactly at cycle+1; busy=1; all other pulses 0.
- 3x3 frame model (9 positions; sample_ready 4 cycles after each req; conv_done 2 cycles after start) -> 9 wen_out pulses at addresses (0,0),(1,0),(2,0),(2,1),(1,1),(0,1),(0,2),(1,2),(2,2); 8 update_pos pulses; pix_count=9; one done pulse.
- end_pos=1 at the first LATCH -> single write of conv_result=0xA5 at (0,0); update_pos never asserted; done follows.
- abort asserted in CONV_WAIT, then conv_done arrives -> state IDLE the next cycle; no wen_out; done=0; a later start runs a full frame normally.
- new_sample_ready withheld for TIMEOUT_CYCLES -> err=1 and busy=0; start clears err and new_trans is pulsed.
- new_sample_ready and conv_done toggled randomly outside their wait states -> no extra req/start/write pulses; pix_count equals the model's pixel count.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: frame-level controller for the Gaussian convolution path.
//   Kicks conv_memory/pixel_pos with new_trans. Then, for each output pixel,
//   it waits for a full window, latches it and steps the position, starts the
//   engine, waits for the result and writes it to the output SRAM.
// Ports:
//   clk, n_rst                       clock, async active-low reset
//   start / abort                    host frame start pulse / level abort
//   new_trans                        window + position reset pulse
//   new_sample_ready/new_sample_req  window handshake with conv_memory
//   update_pos, end_pos, curr_x/y    position handshake with pixel_pos
//   conv_start, conv_done, conv_result  engine handshake
//   wen_out, x/y_addr_out, wdat_out  output SRAM write port
//   busy, done, err, pix_count       status
module conv_sequencer #(
  parameter int X_MAX          = 60,
  parameter int Y_MAX          = 60,
  parameter int PIXEL_DEPTH    = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 12
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     new_trans,
  input  logic                     new_sample_ready,
  output logic                     new_sample_req,
  output logic                     update_pos,
  input  logic                     end_pos,
  input  logic [$clog2(X_MAX)-1:0] curr_x,
  input  logic [$clog2(Y_MAX)-1:0] curr_y,
  output logic                     conv_start,
  input  logic                     conv_done,
  input  logic [PIXEL_DEPTH-1:0]   conv_result,
  output logic                     wen_out,
  output logic [$clog2(X_MAX)-1:0] x_addr_out,
  output logic [$clog2(Y_MAX)-1:0] y_addr_out,
  output logic [PIXEL_DEPTH-1:0]   wdat_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [CNT_W-1:0]         pix_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_SAMPLE, LATCH, CONV, CONV_WAIT, WRITE, DONE, ERROR
  } state_t;

  state_t        state;
  logic          last;
  logic [TW-1:0] tmo;

  // Status decode of the registered state only.
  assign busy = !(state inside {IDLE, DONE, ERROR});

  // Every pulse is registered on the edge that enters its state, so it is
  // high for exactly the one cycle spent in that state. Values that depend on
  // inputs (update_pos, the address, last) are sampled on that same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      new_trans      <= 1'b0;
      new_sample_req <= 1'b0;
      update_pos     <= 1'b0;
      conv_start     <= 1'b0;
      wen_out        <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      x_addr_out     <= '0;
      y_addr_out     <= '0;
      wdat_out       <= '0;
      pix_count      <= '0;
      last           <= 1'b0;
      tmo            <= '0;
    end else begin
      new_trans      <= 1'b0;
      new_sample_req <= 1'b0;
      update_pos     <= 1'b0;
      conv_start     <= 1'b0;
      wen_out        <= 1'b0;
      done           <= 1'b0;
      // The timer only counts while staying in a wait state; any other cycle
      // zeroes it, which gives a fresh count on every wait-state entry.
      tmo            <= '0;
      if (abort) begin
        // Abort wins over everything; err is kept so the host can still see it.
        state <= IDLE;
      end else begin
        case (state)
          IDLE, ERROR: begin
            if (start) begin
              state     <= INIT;
              new_trans <= 1'b1;
              pix_count <= '0;
              err       <= 1'b0;
            end
          end
          INIT: state <= WAIT_SAMPLE;
          WAIT_SAMPLE: begin
            // A ready arriving on the timeout cycle still wins.
            if (new_sample_ready) begin
              state          <= LATCH;
              new_sample_req <= 1'b1;
              update_pos     <= !end_pos;
              x_addr_out     <= curr_x;
              y_addr_out     <= curr_y;
              last           <= end_pos;
            end else if (tmo == TMO_MAX) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          LATCH: begin
            // The engine starts one cycle after the latch so it reads the
            // freshly shifted window.
            state      <= CONV;
            conv_start <= 1'b1;
          end
          CONV: state <= CONV_WAIT;
          CONV_WAIT: begin
            if (conv_done) begin
              state     <= WRITE;
              wdat_out  <= conv_result;
              wen_out   <= 1'b1;
              pix_count <= (&pix_count) ? pix_count : pix_count + 1'b1;
            end else if (tmo == TMO_MAX) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          WRITE: begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_SAMPLE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       new_trans, new_sample_ready, new_sample_req, update_pos, end_pos;
  logic [5:0] curr_x, curr_y, x_addr_out, y_addr_out;
  logic       conv_start, conv_done, wen_out, busy, done, err;
  logic [7:0] conv_result, wdat_out;
  logic [11:0] pix_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  conv_sequencer dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .new_trans(new_trans), .new_sample_ready(new_sample_ready),
    .new_sample_req(new_sample_req), .update_pos(update_pos), .end_pos(end_pos),
    .curr_x(curr_x), .curr_y(curr_y), .conv_start(conv_start),
    .conv_done(conv_done), .conv_result(conv_result), .wen_out(wen_out),
    .x_addr_out(x_addr_out), .y_addr_out(y_addr_out), .wdat_out(wdat_out),
    .busy(busy), .done(done), .err(err), .pix_count(pix_count)
  );

  // ---------------- neighbour models ----------------
  // pixel_pos: serpentine 3x3 raster, frame_len positions long
  logic [5:0] pos_x [9] = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
  logic [5:0] pos_y [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int idx = 0;
  int frame_len = 9;
  always @(posedge clk) begin
    if (new_trans) idx <= 0;
    else if (update_pos) idx <= idx + 1;
  end
  assign curr_x  = (idx < 9) ? pos_x[idx] : 6'd0;
  assign curr_y  = (idx < 9) ? pos_y[idx] : 6'd0;
  assign end_pos = (idx == frame_len - 1);

  // conv_memory: ready 4 cycles after new_trans/req, held until req
  logic     rdy = 1'b0;
  int       rcnt = 0;
  bit       mem_en = 1'b1;
  bit       noise_en = 1'b0;
  bit       nz_a = 1'b0, nz_b = 1'b0;
  always @(posedge clk) begin
    nz_a <= 1'($urandom_range(0, 1));
    nz_b <= 1'($urandom_range(0, 1));
    if (new_trans || new_sample_req) begin
      rdy  <= 1'b0;
      rcnt <= 4;
    end else if (rcnt != 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1 && mem_en) rdy <= 1'b1;
    end
  end
  // Noise is injected only in cycles where the sequencer is known not to be
  // waiting on that input (identified by its one-cycle pulses).
  assign new_sample_ready = rdy | (noise_en & nz_a & (conv_start | new_trans | wen_out));

  // engine: conv_done 2 cycles after conv_start, result = res_base + k
  logic [1:0] sr = 2'b00;
  logic [7:0] res_base = 8'h40;
  logic [7:0] scnt = 8'h00;
  always @(posedge clk) begin
    sr <= {sr[0], conv_start};
    if (new_trans) scnt <= 8'h00;
    else if (conv_start) scnt <= scnt + 8'h01;
  end
  assign conv_result = res_base + scnt - 8'h01;
  assign conv_done = sr[1] |
    (noise_en & nz_b & (new_sample_req | conv_start | wen_out | done | new_trans));

  // ---------------- monitor ----------------
  int cnt_wen = 0, cnt_upd = 0, cnt_req = 0, cnt_cs = 0, cnt_nt = 0, cnt_done = 0;
  logic [5:0] wr_x [64];
  logic [5:0] wr_y [64];
  logic [7:0] wr_d [64];
  always @(negedge clk) begin
    if (n_rst) begin
      if (wen_out) begin
        if (cnt_wen < 64) begin
          wr_x[cnt_wen] <= x_addr_out;
          wr_y[cnt_wen] <= y_addr_out;
          wr_d[cnt_wen] <= wdat_out;
        end
        cnt_wen <= cnt_wen + 1;
      end
      if (update_pos)     cnt_upd  <= cnt_upd + 1;
      if (new_sample_req) cnt_req  <= cnt_req + 1;
      if (conv_start)     cnt_cs   <= cnt_cs + 1;
      if (new_trans)      cnt_nt   <= cnt_nt + 1;
      if (done)           cnt_done <= cnt_done + 1;
    end
  end

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    compared++;
    if ({new_trans, new_sample_req, update_pos, conv_start, wen_out, done, err, busy} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 00000000",
        {new_trans, new_sample_req, update_pos, conv_start, wen_out, done, err, busy});
    end
    compared++;
    if ({x_addr_out, y_addr_out, wdat_out, pix_count} !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_data: got %h want 0", {x_addr_out, y_addr_out, wdat_out, pix_count});
    end
    // start together with abort in IDLE is dropped
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    compared++;
    if ({busy, new_trans} !== 2'b00) begin
      mismatched++;
      $display("FAIL start_abort_idle: busy,new_trans got %b want 00", {busy, new_trans});
    end
  endtask

  task automatic test_frame3x3();
    int b_w, b_u, b_d;
    bit seen;
    frame_len = 9; res_base = 8'h40;
    b_w = cnt_wen; b_u = cnt_upd; b_d = cnt_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if ({new_trans, busy, new_sample_req, update_pos, conv_start, wen_out, done} !== 7'b1100000) begin
      mismatched++;
      $display("FAIL start_latency: got %b want 1100000",
        {new_trans, busy, new_sample_req, update_pos, conv_start, wen_out, done});
    end
    @(negedge clk);
    compared++;
    if (new_trans !== 1'b0) begin
      mismatched++;
      $display("FAIL new_trans_width: got %b want 0", new_trans);
    end
    wait_done(500, seen);
    compared++;
    if (!seen) begin mismatched++; $display("FAIL frame3_done: got timeout want done"); end
    compared++;
    if (cnt_wen - b_w !== 9) begin
      mismatched++; $display("FAIL frame3_writes: got %0d want 9", cnt_wen - b_w);
    end
    compared++;
    if (cnt_upd - b_u !== 8) begin
      mismatched++; $display("FAIL frame3_upd: got %0d want 8", cnt_upd - b_u);
    end
    compared++;
    if (cnt_done - b_d !== 1) begin
      mismatched++; $display("FAIL frame3_done_cnt: got %0d want 1", cnt_done - b_d);
    end
    compared++;
    if (pix_count !== 12'd9) begin
      mismatched++; $display("FAIL frame3_pix_count: got %0d want 9", pix_count);
    end
    for (int k = 0; k < 9; k++) begin
      compared++;
      if ({wr_x[b_w+k], wr_y[b_w+k], wr_d[b_w+k]} !== {pos_x[k], pos_y[k], 8'h40 + 8'(k)}) begin
        mismatched++;
        $display("FAIL frame3_write%0d: got (%0d,%0d)=%h want (%0d,%0d)=%h", k,
          wr_x[b_w+k], wr_y[b_w+k], wr_d[b_w+k], pos_x[k], pos_y[k], 8'h40 + 8'(k));
      end
    end
  endtask

  task automatic test_single_pixel();
    int b_w, b_u, b_d;
    bit seen;
    frame_len = 1; res_base = 8'hA5;
    b_w = cnt_wen; b_u = cnt_upd; b_d = cnt_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, seen);
    compared++;
    if (!seen) begin mismatched++; $display("FAIL single_done: got timeout want done"); end
    compared++;
    if ({cnt_wen - b_w, cnt_upd - b_u, cnt_done - b_d} !== {32'd1, 32'd0, 32'd1}) begin
      mismatched++;
      $display("FAIL single_counts: wen/upd/done got %0d/%0d/%0d want 1/0/1",
        cnt_wen - b_w, cnt_upd - b_u, cnt_done - b_d);
    end
    compared++;
    if ({wr_x[b_w], wr_y[b_w], wr_d[b_w]} !== {6'd0, 6'd0, 8'hA5}) begin
      mismatched++;
      $display("FAIL single_write: got (%0d,%0d)=%h want (0,0)=a5", wr_x[b_w], wr_y[b_w], wr_d[b_w]);
    end
    compared++;
    if (pix_count !== 12'd1) begin
      mismatched++; $display("FAIL single_pix_count: got %0d want 1", pix_count);
    end
    frame_len = 9; res_base = 8'h40;
  endtask

  task automatic test_abort();
    int b_w, b_d;
    bit seen;
    b_w = cnt_wen; b_d = cnt_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (conv_start) begin seen = 1'b1; break; end
    end
    compared++;
    if (!seen) begin mismatched++; $display("FAIL abort_cs: got timeout want conv_start"); end
    @(negedge clk);           // now in CONV_WAIT
    abort = 1'b1;
    @(negedge clk);           // conv_done from the engine is high this cycle
    compared++;
    if ({busy, wen_out, done} !== 3'b000) begin
      mismatched++; $display("FAIL abort_idle: busy,wen,done got %b want 000", {busy, wen_out, done});
    end
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    compared++;
    if ({cnt_wen - b_w, cnt_done - b_d} !== {32'd0, 32'd0} || pix_count !== 12'd0) begin
      mismatched++;
      $display("FAIL abort_no_write: wen/done/pix got %0d/%0d/%0d want 0/0/0",
        cnt_wen - b_w, cnt_done - b_d, pix_count);
    end
    b_w = cnt_wen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500, seen);
    compared++;
    if (!seen || cnt_wen - b_w !== 9 || pix_count !== 12'd9) begin
      mismatched++;
      $display("FAIL abort_restart: done/wen/pix got %0d/%0d/%0d want 1/9/9", seen, cnt_wen - b_w, pix_count);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    mem_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // new_trans cycle is n=0; WAIT_SAMPLE entered at n=1, err rises at n=1025
    for (int n = 1; n <= 1025; n++) begin
      @(negedge clk);
      if (n == 1024) begin
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("FAIL tmo_early: err got %b want 0", err); end
      end
    end
    compared++;
    if ({err, busy} !== 2'b10) begin
      mismatched++; $display("FAIL tmo_err: err,busy got %b want 10", {err, busy});
    end
    mem_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if ({err, new_trans, busy} !== 3'b011) begin
      mismatched++; $display("FAIL tmo_restart: err,new_trans,busy got %b want 011", {err, new_trans, busy});
    end
    wait_done(500, seen);
    compared++;
    if (!seen || pix_count !== 12'd9) begin
      mismatched++; $display("FAIL tmo_frame: done/pix got %0d/%0d want 1/9", seen, pix_count);
    end
  endtask

  task automatic test_noise();
    int b_w, b_r, b_c, b_n, b_d;
    bit seen;
    b_w = cnt_wen; b_r = cnt_req; b_c = cnt_cs; b_n = cnt_nt; b_d = cnt_done;
    noise_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1;             // mid-frame start must be ignored
    @(negedge clk);
    start = 1'b0;
    wait_done(500, seen);
    noise_en = 1'b0;
    compared++;
    if (!seen) begin mismatched++; $display("FAIL noise_done: got timeout want done"); end
    compared++;
    if ({cnt_req - b_r, cnt_cs - b_c, cnt_wen - b_w} !== {32'd9, 32'd9, 32'd9}) begin
      mismatched++;
      $display("FAIL noise_pulses: req/cs/wen got %0d/%0d/%0d want 9/9/9",
        cnt_req - b_r, cnt_cs - b_c, cnt_wen - b_w);
    end
    compared++;
    if ({cnt_nt - b_n, cnt_done - b_d} !== {32'd1, 32'd1} || pix_count !== 12'd9) begin
      mismatched++;
      $display("FAIL noise_frame: nt/done/pix got %0d/%0d/%0d want 1/1/9",
        cnt_nt - b_n, cnt_done - b_d, pix_count);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();            // checked while reset is still asserted
    n_rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_frame3x3();
    test_single_pixel();
    test_abort();
    test_timeout();
    test_noise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
